// File: rtl/nexus_nonce_collector.sv
// -----------------------------------------------------------------------------
// nexus_nonce_collector
//
// Collects GoodNonceFound hits from HASHERS parallel SK1024 hash cores. Each
// core has a single 64-bit holding slot. A round-robin arbiter moves one full
// slot per cycle into a first-word-fall-through FIFO that the host side drains
// with a valid/pop handshake. A hit arriving while its slot is still occupied
// (and not being drained that cycle) is discarded and counted. The hash pipes
// are never stalled.
//
// Optional build macro:
//   NEXUS_NONCE_DEDUP_EN - remember the last nonce written to the FIFO and
//                          silently consume any granted nonce equal to it.
//
// Ports:
//   clk           single clock
//   nHashRst      asynchronous active-low reset
//   Flush         synchronous clear of slots and FIFO; counters are kept
//   NonceIn       core i nonce at [64*i +: 64]
//   NonceValid    core i hit pulse
//   NonceOut      FIFO head nonce (0 when empty)
//   NonceOutValid FIFO non-empty
//   NonceOutPop   consume head; ignored when empty
//   FifoCount     FIFO occupancy 0..DEPTH
//   DropCount     saturating count of discarded nonces
//   Overflow      sticky flag, set on the first drop
// -----------------------------------------------------------------------------
module nexus_nonce_collector #(
    parameter int HASHERS = 4,
    parameter int DEPTH   = 8,
    parameter int DROPW   = 8
) (
    input  logic                     clk,
    input  logic                     nHashRst,
    input  logic                     Flush,
    input  logic [64*HASHERS-1:0]    NonceIn,
    input  logic [HASHERS-1:0]       NonceValid,
    output logic [63:0]              NonceOut,
    output logic                     NonceOutValid,
    input  logic                     NonceOutPop,
    output logic [$clog2(DEPTH):0]   FifoCount,
    output logic [DROPW-1:0]         DropCount,
    output logic                     Overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int IW = (HASHERS > 1) ? $clog2(HASHERS) : 1;
    localparam int SW = DROPW + 5;
    localparam logic [DROPW-1:0] DROP_MAX = '1;

    // ------------------------------------------------------------------
    // Shared control
    // ------------------------------------------------------------------
    logic [HASHERS-1:0] slot_full;
    logic [63:0]        slot_val [HASHERS];
    logic [HASHERS-1:0] slot_drop;

    logic               grant_any;
    logic               grant_vld;
    logic [IW-1:0]      grant_idx;
    logic [63:0]        grant_nonce;
    logic               is_dup;
    logic               wr_en;
    logic               pop_eff;
    logic               room;

    logic [IW-1:0]      rr_q, rr_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic [DROPW-1:0]   drop_q, drop_d;
    logic               ovf_q, ovf_d;

    logic [63:0]        mem [DEPTH];

    // A pop is only real when there is something to pop and no flush.
    assign pop_eff = NonceOutPop && (count_q != '0) && !Flush;
    // Room exists when not full, or when full but the head leaves this cycle.
    assign room    = (count_q < CW'(DEPTH)) || pop_eff;
    assign grant_vld   = grant_any && room && !Flush;
    assign grant_nonce = slot_val[grant_idx];
    assign wr_en       = grant_vld && !is_dup;

    // ------------------------------------------------------------------
    // Per-core holding slots
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < HASHERS; gi++) begin : g_slot
        logic        full_q, full_d;
        logic [63:0] val_q, val_d;
        logic        granted;
        logic        blocked;

        assign granted = grant_vld && (grant_idx == IW'(gi));
        // Occupied and not leaving this cycle: a new hit cannot be accepted.
        assign blocked = full_q && !granted;
        assign slot_drop[gi] = !Flush && NonceValid[gi] && blocked;
        assign slot_full[gi] = full_q;
        assign slot_val[gi]  = val_q;

        always_comb begin
            full_d = full_q;
            val_d  = val_q;
            if (Flush) begin
                full_d = 1'b0;
            end else if (NonceValid[gi] && !blocked) begin
                // Covers both an empty slot and a reload of the slot being granted.
                full_d = 1'b1;
                val_d  = NonceIn[64*gi +: 64];
            end else if (granted) begin
                full_d = 1'b0;
            end
        end

        always_ff @(posedge clk or negedge nHashRst) begin
            if (!nHashRst) begin
                full_q <= 1'b0;
                val_q  <= '0;
            end else begin
                full_q <= full_d;
                val_q  <= val_d;
            end
        end
    end

    // ------------------------------------------------------------------
    // Round-robin arbiter: rr_q is the highest-priority index. Scanning
    // downwards makes the candidate closest to rr_q win.
    // ------------------------------------------------------------------
    always_comb begin
        logic [IW:0] cand;
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = HASHERS - 1; k >= 0; k--) begin
            cand = {1'b0, rr_q} + (IW + 1)'(k);
            if (cand >= (IW + 1)'(HASHERS)) begin
                cand = cand - (IW + 1)'(HASHERS);
            end
            if (slot_full[cand[IW-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = cand[IW-1:0];
            end
        end
    end

    always_comb begin
        logic [IW:0] nxt;
        rr_d = rr_q;
        nxt  = {1'b0, grant_idx} + (IW + 1)'(1);
        if (nxt >= (IW + 1)'(HASHERS)) begin
            nxt = '0;
        end
        if (grant_vld) begin
            rr_d = nxt[IW-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Duplicate suppression
    // ------------------------------------------------------------------
`ifdef NEXUS_NONCE_DEDUP_EN
    logic [63:0] last_q, last_d;
    logic        last_vld_q, last_vld_d;

    assign is_dup = last_vld_q && (grant_nonce == last_q);

    always_comb begin
        last_d     = last_q;
        last_vld_d = last_vld_q;
        if (Flush) begin
            last_d     = '0;
            last_vld_d = 1'b0;
        end else if (wr_en) begin
            last_d     = grant_nonce;
            last_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nHashRst) begin
        if (!nHashRst) begin
            last_q     <= '0;
            last_vld_q <= 1'b0;
        end else begin
            last_q     <= last_d;
            last_vld_q <= last_vld_d;
        end
    end
`else
    assign is_dup = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (Flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop_eff) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (wr_en && !pop_eff) begin
                count_d = count_q + CW'(1);
            end else if (pop_eff && !wr_en) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    // Storage has no reset; the head is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= grant_nonce;
        end
    end

    // ------------------------------------------------------------------
    // Drop accounting: several slots may collide in the same cycle.
    // ------------------------------------------------------------------
    always_comb begin
        logic [SW-1:0] drop_sum;
        logic [SW-1:0] drop_acc;
        drop_sum = '0;
        for (int i = 0; i < HASHERS; i++) begin
            drop_sum = drop_sum + SW'(slot_drop[i]);
        end
        drop_acc = SW'(drop_q) + drop_sum;
        drop_d   = (drop_acc > SW'(DROP_MAX)) ? DROP_MAX : drop_acc[DROPW-1:0];
        ovf_d    = ovf_q | (|slot_drop);
    end

    always_ff @(posedge clk or negedge nHashRst) begin
        if (!nHashRst) begin
            rr_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            rr_q     <= rr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
            ovf_q    <= ovf_d;
        end
    end

    assign NonceOutValid = (count_q != '0);
    assign NonceOut      = NonceOutValid ? mem[rd_ptr_q] : '0;
    assign FifoCount     = count_q;
    assign DropCount     = drop_q;
    assign Overflow      = ovf_q;

endmodule
